// File: rtl/game_pkg.sv
// Shared game constants: one-hot game states and default widths.
// Imported by the sequencer and the pipe, bird and render blocks.
package game_pkg;

  localparam int GAME_STATE_W = 4;
  localparam int DEF_SCORE_W  = 32;

  typedef enum logic [GAME_STATE_W-1:0] {
    START_SCREEN = 4'b0001,
    IN_GAME      = 4'b0010,
    PAUSE        = 4'b0100,
    END_SCREEN   = 4'b1000
  } game_state_t;

endpackage

// File: rtl/game_flow_ctrl_btn_edge.sv
// Rising-edge detector for a button level already synchronous to FL_clk.
// A held button yields a single one-frame event.
module btn_edge (
  input  logic FL_clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  logic btn_q;

  always_ff @(posedge FL_clk or posedge rst) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn;
  end

  assign evt = btn & ~btn_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Frame-rate game sequencer driving the one-hot game_state bus.
// Define AUTO_RESTART_EN to leave END_SCREEN without a flap once the hold expires.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int END_HOLD_FRAMES = 120,
  parameter int SCORE_W         = DEF_SCORE_W
) (
  input  logic                    FL_clk,
  input  logic                    rst,
  input  logic                    flap_btn,
  input  logic                    pause_btn,
  input  logic                    collision,
  input  logic [SCORE_W-1:0]      score_count,
  output logic [GAME_STATE_W-1:0] game_state,
  output logic                    flap_pulse,
  output logic [SCORE_W-1:0]      high_score,
  output logic                    new_high
);

  localparam int HOLD_W = (END_HOLD_FRAMES < 1) ? 1
                        : $clog2(END_HOLD_FRAMES + 1);

  game_state_t        state_q, state_d;
  logic               pulse_q, pulse_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic               nh_q, nh_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               flap_evt, pause_evt;
  logic               hold_done;

  btn_edge u_flap_edge (
    .FL_clk (FL_clk),
    .rst    (rst),
    .btn    (flap_btn),
    .evt    (flap_evt)
  );

  btn_edge u_pause_edge (
    .FL_clk (FL_clk),
    .rst    (rst),
    .btn    (pause_btn),
    .evt    (pause_evt)
  );

  assign hold_done = (hold_q == '0);

  always_ff @(posedge FL_clk or posedge rst) begin
    if (rst) begin
      state_q <= START_SCREEN;
      pulse_q <= 1'b0;
      high_q  <= '0;
      nh_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      high_q  <= high_d;
      nh_q    <= nh_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    high_d  = high_q;
    nh_d    = nh_q;
    hold_d  = hold_q;
    case (state_q)
      START_SCREEN: begin
        if (flap_evt) begin
          state_d = IN_GAME;
          pulse_d = 1'b1;
        end
      end
      IN_GAME: begin
        if (collision) begin
          state_d = END_SCREEN;
          hold_d  = HOLD_W'(END_HOLD_FRAMES);
          nh_d    = (score_count > high_q);
          if (score_count > high_q) high_d = score_count;
        end else if (pause_evt) begin
          state_d = PAUSE;
        end else if (flap_evt) begin
          pulse_d = 1'b1;
        end
      end
      PAUSE: begin
        if (pause_evt) state_d = IN_GAME;
      end
      END_SCREEN: begin
        if (!hold_done) hold_d = hold_q - HOLD_W'(1);
`ifdef AUTO_RESTART_EN
        if (hold_done) begin
`else
        if (hold_done && flap_evt) begin
`endif
          state_d = START_SCREEN;
          nh_d    = 1'b0;
        end
      end
      // Corrupted encodings fall back to the title screen.
      default: begin
        state_d = START_SCREEN;
        nh_d    = 1'b0;
      end
    endcase
  end

  assign game_state = state_q;
  assign flap_pulse = pulse_q;
  assign high_score = high_q;
  assign new_high   = nh_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Randomized scoreboard bench for game_flow_ctrl against a frame-level model.
// Driver pushes expected post-edge outputs; a monitor pops and compares.
module tb_game_flow_ctrl;

  localparam int HOLD = 3;
  localparam int SW   = 32;

  logic          FL_clk = 1'b0;
  logic          rst;
  logic          flap_btn, pause_btn, collision;
  logic [SW-1:0] score_count;
  logic [3:0]    game_state;
  logic          flap_pulse;
  logic [SW-1:0] high_score;
  logic          new_high;

  game_flow_ctrl #(
    .END_HOLD_FRAMES (HOLD),
    .SCORE_W         (SW)
  ) dut (
    .FL_clk      (FL_clk),
    .rst         (rst),
    .flap_btn    (flap_btn),
    .pause_btn   (pause_btn),
    .collision   (collision),
    .score_count (score_count),
    .game_state  (game_state),
    .flap_pulse  (flap_pulse),
    .high_score  (high_score),
    .new_high    (new_high)
  );

  always #5 FL_clk = ~FL_clk;

  typedef struct packed {
    logic [3:0]    st;
    logic          pulse;
    logic [SW-1:0] hi;
    logic          nh;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Model: mode 0 title, 1 playing, 2 paused, 3 game over.
  int          m_mode;
  int          m_hold;
  logic [SW-1:0] m_hi;
  bit          m_nh;
  bit          m_pf, m_pp;

  function automatic void model_reset();
    m_mode = 0;
    m_hold = 0;
    m_hi   = '0;
    m_nh   = 0;
    m_pf   = 0;
    m_pp   = 0;
  endfunction

  task automatic chk(input string name, input exp_t act, input exp_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got st=%b pulse=%b hi=%0d nh=%b, want st=%b pulse=%b hi=%0d nh=%b",
               name, act.st, act.pulse, act.hi, act.nh,
               e.st, e.pulse, e.hi, e.nh);
    end
  endtask

  function automatic exp_t dut_out();
    exp_t a;
    a.st    = game_state;
    a.pulse = flap_pulse;
    a.hi    = high_score;
    a.nh    = new_high;
    return a;
  endfunction

  task automatic drive(input bit f, input bit p, input bit c,
                       input logic [SW-1:0] s);
    bit   fe, pe, pulse, auto_rs;
    exp_t e;
    @(negedge FL_clk);
    flap_btn    = f;
    pause_btn   = p;
    collision   = c;
    score_count = s;
    fe    = f && !m_pf;
    pe    = p && !m_pp;
    m_pf  = f;
    m_pp  = p;
    pulse = 0;
`ifdef AUTO_RESTART_EN
    auto_rs = 1;
`else
    auto_rs = 0;
`endif
    case (m_mode)
      0: if (fe) begin m_mode = 1; pulse = 1; end
      1: begin
        if (c) begin
          m_mode = 3;
          m_hold = HOLD;
          m_nh   = (s > m_hi);
          if (s > m_hi) m_hi = s;
        end else if (pe) m_mode = 2;
        else if (fe) pulse = 1;
      end
      2: if (pe) m_mode = 1;
      default: begin
        if (m_hold == 0 && (fe || auto_rs)) begin
          m_mode = 0;
          m_nh   = 0;
        end
        if (m_hold > 0) m_hold--;
      end
    endcase
    e.st    = 4'(1 << m_mode);
    e.pulse = pulse;
    e.hi    = m_hi;
    e.nh    = m_nh;
    sbq.push_back(e);
  endtask

  always @(posedge FL_clk) begin
    #1;
    if (sbq.size() > 0) chk("frame", dut_out(), sbq.pop_front());
  end

  // Steer the model into play from whatever state it is in.
  task automatic goto_game();
    for (int i = 0; i < 40 && m_mode != 1; i++) begin
      if (m_mode == 2) drive(0, !m_pp, 0, 0);
      else             drive(!m_pf, 0, 0, 0);
    end
  endtask

  task automatic end_run(input logic [SW-1:0] s);
    goto_game();
    drive(0, 0, 1, s);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    flap_btn = 0; pause_btn = 0; collision = 0; score_count = '0;
    model_reset();
    repeat (2) @(negedge FL_clk);
    e = '{st: 4'b0001, pulse: 1'b0, hi: '0, nh: 1'b0};
    chk("reset", dut_out(), e);
    rst = 1'b0;

    // Held flap: one pulse only.
    repeat (5) drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    // Collision beats pause and flap in the same frame.
    drive(1, 1, 1, 4);
    drive(0, 0, 0, 0);
    // Pause, ignored collision/flap, unpause.
    end_run(0);
    goto_game();
    drive(0, 1, 0, 0);
    drive(1, 0, 1, 0);
    drive(0, 1, 0, 0);
    // High-score sequence 7, 7, 9 with hold-window flaps.
    end_run(7);
    for (int i = 0; i < 6; i++) drive(i[0] == 1'b0, 0, 0, 0);
    end_run(7);
    for (int i = 0; i < 6; i++) drive(i[0] == 1'b0, 0, 0, 0);
    end_run(9);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0);

    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0, SW'($urandom_range(0, 12)));

    // Asynchronous reset mid-run.
    end_run(11);
    for (int i = 0; i < 8; i++) drive(i[0] == 1'b0, 0, 0, 0);
    goto_game();
    @(negedge FL_clk);
    #2 rst = 1'b1;
    #1;
    e = '{st: 4'b0001, pulse: 1'b0, hi: '0, nh: 1'b0};
    chk("async_reset", dut_out(), e);
    flap_btn = 0; pause_btn = 0; collision = 0;
    model_reset();
    @(negedge FL_clk);
    rst = 1'b0;
    for (int i = 0; i < 200; i++)
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0, SW'($urandom_range(0, 12)));

    repeat (3) @(negedge FL_clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Frame-rate game sequencer that owns the one-hot game_state bus consumed by the pipe, bird and render blocks. It turns raw flap/pause buttons into edge events and reacts to collisions. It gates flap pulses to the bird physics and captures the high score when a run ends. It runs entirely on the frame clock FL_clk, alongside the pipe datapath.

Parameters:
END_HOLD_FRAMES, 120, frames spent in END_SCREEN before a restart is accepted; 0 means restart is accepted immediately.
SCORE_W, 32, width of score_count and high_score.

Ports:
FL_clk  input  1  frame clock; all logic on its rising edge.
rst  input  1  reset, asynchronous, active-high.
flap_btn  input  1  flap button level, already synchronous to FL_clk.
pause_btn  input  1  pause button level, already synchronous to FL_clk.
collision  input  1  level from the collision detector; high while the bird overlaps a pipe or a boundary.
score_count  input  SCORE_W  current run score from the pipe block.
game_state  output  4  one-hot: 0001 START_SCREEN, 0010 IN_GAME, 0100 PAUSE, 1000 END_SCREEN.
flap_pulse  output  1  one-FL_clk pulse to the bird physics.
high_score  output  SCORE_W  best score since reset.
new_high  output  1  high while in END_SCREEN if the last run set a new high score.

Behaviour:
- Reset (async, any time, including mid-run): game_state=0001; flap_pulse=0; high_score=0; new_high=0; hold counter=0; button history registers=0.
- Button events: flap_evt = flap_btn & ~flap_q; pause_evt = pause_btn & ~pause_q. A held button produces exactly one event.
- All outputs are registered. A transition or pulse appears on the FL_clk edge after the qualifying input cycle (latency 1).
- START_SCREEN:
  - flap_evt -> IN_GAME, with flap_pulse=1 on the same edge.
  - pause_evt and collision are ignored.
- IN_GAME, priority collision > pause_evt > flap_evt:
  - collision -> END_SCREEN; flap_pulse=0 even if flap_evt is present.
  - Else pause_evt -> PAUSE; flap_pulse=0.
  - Else flap_evt -> stay in IN_GAME with flap_pulse=1.
- PAUSE:
  - pause_evt -> IN_GAME.
  - flap_evt and collision are ignored; flap_pulse stays 0.
- END_SCREEN entry, on the IN_GAME->END edge:
  - Hold counter loads END_HOLD_FRAMES.
  - If score_count > high_score (unsigned, using the value sampled in the collision cycle): high_score <= score_count and new_high <= 1.
  - An equal score does not set new_high.
- END_SCREEN steady state:
  - Hold counter decrements once per frame and saturates at 0.
  - Hold counter == 0 and flap_evt -> START_SCREEN, clearing new_high.
  - flap_evt while the counter is nonzero is discarded, not queued.
- flap_pulse is 1 only on the two edges listed above; otherwise 0.
- Hold counter width is $clog2(END_HOLD_FRAMES+1), minimum 1 bit.
- Any non-one-hot game_state value recovers to START_SCREEN on the next edge.

Optional Feature:
AUTO_RESTART_EN:
- Defined: END_SCREEN returns to START_SCREEN automatically on the edge after the hold counter reaches 0, with no flap needed. A flap_evt at counter 0 also restarts. new_high clears on exit.
- Undefined: END_SCREEN is held indefinitely until flap_evt arrives with the counter at 0.

Decomposition:
- Shared package game_pkg:
  - state localparams START_SCREEN, IN_GAME, PAUSE, END_SCREEN (4-bit one-hot);
  - GAME_STATE_W=4;
  - default SCORE_W.
  - The pipe, bird and render blocks import these same constants.
- Sub-module btn_edge: one-bit rising-edge detector with async reset. Instantiated twice, for flap and pause.

Test Plan:
1. Reset, hold flap_btn=1 for 5 frames -> one flap_pulse, game_state 0001->0010 one edge after the rise; no further pulses while held.
2. IN_GAME, collision and pause_evt and flap_evt in the same frame -> game_state=1000, flap_pulse=0.
3. IN_GAME, pause_evt -> 0100; collision=1 plus flap_evt while paused -> stays 0100; second pause_evt -> 0010.
4. Run ends with score_count=7, high_score=0 -> high_score=7, new_high=1. Next run ends at 7 -> high_score=7, new_high=0. Run after that ends at 9 -> 9, new_high=1.
5. END_HOLD_FRAMES=3: flap_evt at hold frames 1-3 is ignored; flap_evt at frame 4 -> 0001 and new_high=0. With AUTO_RESTART_EN and no flap -> 0001 on the edge after the counter reaches 0.
6. Assert rst mid-IN_GAME with high_score=9 -> immediately game_state=0001, high_score=0, flap_pulse=0.
